// File: rtl/csr_commit_unit.sv
// rtl/csr_commit_unit.sv - writeback-stage commit controller driving the CSR file and fetch redirect
module csr_commit_unit #(
   parameter logic [5:0] ECODE_INT = 6'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ms_to_ws_valid,
   output logic        ws_allow_in,
   input  logic [31:0] ms_pc,
   input  logic [31:0] ms_vaddr,
   input  logic [1:0]  ms_csr_op,
   input  logic [13:0] ms_csr_num,
   input  logic [31:0] ms_rd_value,
   input  logic [31:0] ms_rj_value,
   input  logic        ms_ertn,
   input  logic        ms_ex,
   input  logic [5:0]  ms_ecode,
   input  logic [8:0]  ms_esubcode,
   input  logic        ms_gr_we,
   input  logic [4:0]  ms_dest,
   input  logic [31:0] ms_result,
   input  logic        has_int,
   output logic        csr_re,
   output logic        csr_we,
   output logic [13:0] csr_num,
   output logic [31:0] csr_wmask,
   output logic [31:0] csr_wvalue,
   input  logic [31:0] csr_rvalue,
   output logic        wb_ex,
   output logic        ertn_flush,
   output logic [5:0]  wb_ecode,
   output logic [8:0]  wb_esubcode,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_vaddr,
   input  logic [31:0] excep_entry,
   output logic        flush_req,
   output logic [31:0] flush_pc,
   input  logic        fs_redirect_ack,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        ws_valid
);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t      state;
   logic [1:0]  op_r;
   logic [13:0] num_r;
   logic [31:0] rd_value_r;
   logic [31:0] rj_value_r;
   logic [31:0] result_r;
   logic [4:0]  dest_r;
   logic        ertn_r;
   logic        ex_r;
   logic        gr_we_r;
   logic        live;
   logic        commit_flush;

   assign ws_allow_in  = 1'b1;
   assign live         = ws_valid && (state == RUN);

   assign csr_re       = live && (op_r != 2'd0) && !ex_r;
   assign csr_we       = live && op_r[1] && !ex_r;
   assign csr_num      = num_r;
   assign csr_wmask    = (op_r == 2'd3) ? rj_value_r : 32'hFFFF_FFFF;
   assign csr_wvalue   = rd_value_r;

   // csr_rvalue is the pre-write value, so xchg/rd return the old CSR contents
   assign rf_we        = live && gr_we_r && !ex_r;
   assign rf_waddr     = dest_r;
   assign rf_wdata     = (op_r != 2'd0) ? csr_rvalue : result_r;

   assign wb_ex        = live && ex_r;
   assign ertn_flush   = live && ertn_r && !ex_r;
   assign commit_flush = wb_ex || ertn_flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         ws_valid    <= 1'b0;
         flush_req   <= 1'b0;
         flush_pc    <= 32'h0;
         op_r        <= 2'd0;
         num_r       <= 14'h0;
         rd_value_r  <= 32'h0;
         rj_value_r  <= 32'h0;
         result_r    <= 32'h0;
         dest_r      <= 5'h0;
         ertn_r      <= 1'b0;
         ex_r        <= 1'b0;
         gr_we_r     <= 1'b0;
         wb_ecode    <= 6'h0;
         wb_esubcode <= 9'h0;
         wb_pc       <= 32'h0;
         wb_vaddr    <= 32'h0;
      end else begin
         case (state)
            RUN: begin
               if (commit_flush) begin
                  // Committing instruction stays latched so wb_* fields remain stable during the redirect
                  state     <= FLUSH;
                  ws_valid  <= 1'b0;
                  flush_req <= 1'b1;
                  flush_pc  <= excep_entry;
               end else begin
                  ws_valid   <= ms_to_ws_valid;
                  op_r       <= ms_csr_op;
                  num_r      <= ms_csr_num;
                  rd_value_r <= ms_rd_value;
                  rj_value_r <= ms_rj_value;
                  result_r   <= ms_result;
                  dest_r     <= ms_dest;
                  ertn_r     <= ms_ertn;
                  gr_we_r    <= ms_gr_we;
                  wb_pc      <= ms_pc;
                  wb_vaddr   <= ms_vaddr;
                  if (has_int) begin
                     ex_r        <= 1'b1;
                     wb_ecode    <= ECODE_INT;
                     wb_esubcode <= 9'h0;
                  end else begin
                     ex_r        <= ms_ex;
                     wb_ecode    <= ms_ecode;
                     wb_esubcode <= ms_esubcode;
                  end
               end
            end
            FLUSH: begin
               ws_valid <= 1'b0;
               if (fs_redirect_ack) begin
                  state     <= RUN;
                  flush_req <= 1'b0;
               end
            end
            default: begin
               state     <= RUN;
               flush_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_commit_unit.sv
// tb/tb_csr_commit_unit.sv - directed self-checking bench for csr_commit_unit
module tb_csr_commit_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ms_to_ws_valid = 1'b0;
   logic        ws_allow_in;
   logic [31:0] ms_pc = '0, ms_vaddr = '0;
   logic [1:0]  ms_csr_op = '0;
   logic [13:0] ms_csr_num = '0;
   logic [31:0] ms_rd_value = '0, ms_rj_value = '0;
   logic        ms_ertn = 1'b0, ms_ex = 1'b0;
   logic [5:0]  ms_ecode = '0;
   logic [8:0]  ms_esubcode = '0;
   logic        ms_gr_we = 1'b0;
   logic [4:0]  ms_dest = '0;
   logic [31:0] ms_result = '0;
   logic        has_int = 1'b0;
   logic        csr_re, csr_we;
   logic [13:0] csr_num;
   logic [31:0] csr_wmask, csr_wvalue;
   logic [31:0] csr_rvalue = '0;
   logic        wb_ex, ertn_flush;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc, wb_vaddr;
   logic [31:0] excep_entry = '0;
   logic        flush_req;
   logic [31:0] flush_pc;
   logic        fs_redirect_ack = 1'b0;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        ws_valid;

   int vectors = 0;
   int miscompares = 0;

   csr_commit_unit dut (
      .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allow_in(ws_allow_in),
      .ms_pc(ms_pc), .ms_vaddr(ms_vaddr), .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num),
      .ms_rd_value(ms_rd_value), .ms_rj_value(ms_rj_value), .ms_ertn(ms_ertn), .ms_ex(ms_ex),
      .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
      .ms_result(ms_result), .has_int(has_int), .csr_re(csr_re), .csr_we(csr_we),
      .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
      .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
      .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .excep_entry(excep_entry), .flush_req(flush_req),
      .flush_pc(flush_pc), .fs_redirect_ack(fs_redirect_ack), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .ws_valid(ws_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ms();
      ms_to_ws_valid = 1'b0; ms_csr_op = 2'd0; ms_ertn = 1'b0; ms_ex = 1'b0;
      ms_gr_we = 1'b0; ms_ecode = '0; ms_esubcode = '0; has_int = 1'b0;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_ws_valid", ws_valid, 0);
      chk("rst_flush_req", flush_req, 0);
      chk("rst_flush_pc", flush_pc, 0);
      chk("rst_allow_in", ws_allow_in, 1);
      chk("rst_wb_pc", wb_pc, 0);
      chk("rst_csr_re", csr_re, 0);
      tick();
      reset = 1'b0;

      // csrxchg
      ms_to_ws_valid = 1; ms_csr_op = 2'd3; ms_csr_num = 14'h30; ms_rd_value = 32'hA5A5_0000;
      ms_rj_value = 32'hFFFF_0000; ms_gr_we = 1; ms_dest = 5'd5;
      tick();
      clear_ms();
      csr_rvalue = 32'h1234_5678;
      #1;
      chk("xchg_csr_re", csr_re, 1);
      chk("xchg_csr_we", csr_we, 1);
      chk("xchg_csr_num", csr_num, 32'h30);
      chk("xchg_wmask", csr_wmask, 32'hFFFF_0000);
      chk("xchg_wvalue", csr_wvalue, 32'hA5A5_0000);
      chk("xchg_rf_we", rf_we, 1);
      chk("xchg_rf_waddr", rf_waddr, 5);
      chk("xchg_rf_wdata", rf_wdata, 32'h1234_5678);

      // csrwr: full write mask
      ms_to_ws_valid = 1; ms_csr_op = 2'd2; ms_rj_value = 32'h0000_00FF; ms_rd_value = 32'h0BAD_F00D;
      tick();
      clear_ms();
      chk("wr_wmask", csr_wmask, 32'hFFFF_FFFF);
      chk("wr_wvalue", csr_wvalue, 32'h0BAD_F00D);

      // plain ALU writeback, no CSR access
      ms_to_ws_valid = 1; ms_gr_we = 1; ms_dest = 5'd7; ms_result = 32'hDEAD_BEEF;
      tick();
      clear_ms();
      chk("alu_csr_re", csr_re, 0);
      chk("alu_rf_we", rf_we, 1);
      chk("alu_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
      tick();
      chk("idle_ws_valid", ws_valid, 0);
      chk("idle_rf_we", rf_we, 0);

      // ack in RUN is ignored
      fs_redirect_ack = 1;
      tick();
      fs_redirect_ack = 0;
      chk("ack_run_flush_req", flush_req, 0);

      // carried exception
      ms_to_ws_valid = 1; ms_ex = 1; ms_ecode = 6'h9; ms_vaddr = 32'h8000_0003;
      ms_pc = 32'h1C00_0100; ms_csr_op = 2'd2; ms_gr_we = 1;
      tick();
      clear_ms();
      excep_entry = 32'h1C00_8000;
      #1;
      chk("exc_wb_ex", wb_ex, 1);
      chk("exc_ecode", wb_ecode, 9);
      chk("exc_pc", wb_pc, 32'h1C00_0100);
      chk("exc_vaddr", wb_vaddr, 32'h8000_0003);
      chk("exc_rf_we", rf_we, 0);
      chk("exc_csr_we", csr_we, 0);
      chk("exc_flush_req_n1", flush_req, 0);
      tick();
      excep_entry = 32'h0000_0000;
      chk("exc_wb_ex_pulse", wb_ex, 0);
      chk("exc_flush_req", flush_req, 1);
      chk("exc_flush_pc", flush_pc, 32'h1C00_8000);
      tick();
      chk("exc_flush_req_hold", flush_req, 1);
      chk("exc_flush_pc_hold", flush_pc, 32'h1C00_8000);
      fs_redirect_ack = 1;
      tick();
      fs_redirect_ack = 0;
      chk("exc_flush_req_drop", flush_req, 0);

      // interrupt over csrwr
      ms_to_ws_valid = 1; ms_csr_op = 2'd2; has_int = 1; ms_ecode = 6'h5; ms_esubcode = 9'h3;
      tick();
      clear_ms();
      chk("int_wb_ex", wb_ex, 1);
      chk("int_ecode", wb_ecode, 0);
      chk("int_esub", wb_esubcode, 0);
      chk("int_csr_we", csr_we, 0);
      tick();
      fs_redirect_ack = 1;
      tick();
      fs_redirect_ack = 0;

      // ertn, then stream instructions during FLUSH
      ms_to_ws_valid = 1; ms_ertn = 1;
      tick();
      ms_ertn = 0; ms_gr_we = 1; ms_dest = 5'd9; ms_result = 32'h5555_AAAA;
      excep_entry = 32'h1C00_0040;
      #1;
      chk("ertn_flush", ertn_flush, 1);
      chk("ertn_wb_ex", wb_ex, 0);
      tick();
      chk("ertn_pulse", ertn_flush, 0);
      chk("ertn_flush_pc", flush_pc, 32'h1C00_0040);
      chk("ertn_stream_rf_we1", rf_we, 0);
      tick();
      chk("ertn_stream_rf_we2", rf_we, 0);
      fs_redirect_ack = 1;
      tick();
      fs_redirect_ack = 0;
      clear_ms();
      chk("ertn_stream_rf_we3", rf_we, 0);
      chk("ertn_ack_discard", ws_valid, 0);
      chk("ertn_flush_req_drop", flush_req, 0);

      // ertn with exception, then reset two cycles into FLUSH
      ms_to_ws_valid = 1; ms_ertn = 1; ms_ex = 1; ms_ecode = 6'h7;
      tick();
      clear_ms();
      chk("ertnex_wb_ex", wb_ex, 1);
      chk("ertnex_ertn_flush", ertn_flush, 0);
      tick();
      chk("ertnex_flush_req", flush_req, 1);
      tick();
      #2;
      reset = 1;
      #1;
      chk("rstfl_flush_req", flush_req, 0);
      chk("rstfl_wb_ex", wb_ex, 0);
      chk("rstfl_ertn", ertn_flush, 0);
      tick();
      reset = 0;
      ms_to_ws_valid = 1; ms_gr_we = 1; ms_dest = 5'd3; ms_result = 32'h0000_1111;
      tick();
      clear_ms();
      chk("post_rst_ws_valid", ws_valid, 1);
      chk("post_rst_rf_we", rf_we, 1);
      chk("post_rst_rf_wdata", rf_wdata, 32'h0000_1111);
      chk("post_rst_flush_req", flush_req, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
